// File: rtl/entrada_antirrebote_if.sv
// Button bundle between the raw push-button pins and the conditioned outputs
// consumed by the counter stage.
interface entrada_antirrebote_if #(
  parameter int NUM_BTN = 2
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (output btn_in, input btn_level, btn_press, btn_release);
  modport slave (input btn_in, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/entrada_antirrebote.sv
// Per-button synchronizer, debounce FSM and press/release pulse generator.
// Define AUTO_REPEAT_EN to add hold-to-repeat press pulses.
module entrada_antirrebote #(
  parameter int NUM_BTN       = 2,
  parameter int DEB_CYCLES    = 16,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  entrada_antirrebote_if.slave btn
);
  localparam int MAX_AB  = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  logic [NUM_BTN-1:0] level_vec;
  logic [NUM_BTN-1:0] press_vec;
  logic [NUM_BTN-1:0] release_vec;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    logic          raw;
    logic          sync_a_reg;
    logic          sync_b_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          press_evt_reg, press_evt_next;
    logic          release_evt_reg, release_evt_next;
    logic          level_out_reg;
    logic          press_out_reg;
    logic          release_out_reg;
`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] DELAY_T  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_T = CW'(REPEAT_PERIOD);
    logic [CW-1:0] hold_reg, hold_next;
    logic          rep_reg, rep_next;
    logic [CW-1:0] hold_target;
`endif

    assign raw = ACTIVE_LOW ? ~btn.btn_in[gi] : btn.btn_in[gi];

    // The FSM decides an event one edge before the outputs show it, which
    // gives the 2+DEB_CYCLES edge latency from the first pressed sample.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_a_reg      <= 1'b0;
        sync_b_reg      <= 1'b0;
        state_reg       <= IDLE;
        cnt_reg         <= '0;
        press_evt_reg   <= 1'b0;
        release_evt_reg <= 1'b0;
        level_out_reg   <= 1'b0;
        press_out_reg   <= 1'b0;
        release_out_reg <= 1'b0;
`ifdef AUTO_REPEAT_EN
        hold_reg        <= '0;
        rep_reg         <= 1'b0;
`endif
      end else begin
        sync_a_reg      <= raw;
        sync_b_reg      <= sync_a_reg;
        state_reg       <= state_next;
        cnt_reg         <= cnt_next;
        press_evt_reg   <= press_evt_next;
        release_evt_reg <= release_evt_next;
        level_out_reg   <= (state_reg == PRESSED) || (state_reg == DEB_RELEASE);
        press_out_reg   <= press_evt_reg;
        release_out_reg <= release_evt_reg;
`ifdef AUTO_REPEAT_EN
        hold_reg        <= hold_next;
        rep_reg         <= rep_next;
`endif
      end
    end

    always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      press_evt_next   = 1'b0;
      release_evt_next = 1'b0;
`ifdef AUTO_REPEAT_EN
      hold_next        = hold_reg;
      rep_next         = rep_reg;
      hold_target      = rep_reg ? PERIOD_T : DELAY_T;
`endif
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
`ifdef AUTO_REPEAT_EN
          hold_next = '0;
          rep_next  = 1'b0;
`endif
          if (sync_b_reg) begin
            state_next = DEB_PRESS;
            cnt_next   = CNT_ONE;
          end
        end
        DEB_PRESS: begin
          if (!sync_b_reg) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt_reg >= DEB_LAST) begin
            state_next     = PRESSED;
            cnt_next       = '0;
            press_evt_next = 1'b1;
          end else if (cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync_b_reg) begin
            state_next = DEB_RELEASE;
            cnt_next   = CNT_ONE;
          end else begin
`ifdef AUTO_REPEAT_EN
            // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
            if (hold_reg == hold_target) begin
              press_evt_next = 1'b1;
              hold_next      = CNT_ONE;
              rep_next       = 1'b1;
            end else if (hold_reg != CNT_SAT) begin
              hold_next = hold_reg + CNT_ONE;
            end
`endif
          end
        end
        DEB_RELEASE: begin
          if (sync_b_reg) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (cnt_reg >= DEB_LAST) begin
            state_next       = IDLE;
            cnt_next         = '0;
            release_evt_next = 1'b1;
`ifdef AUTO_REPEAT_EN
            hold_next = '0;
            rep_next  = 1'b0;
`endif
          end else if (cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    assign level_vec[gi]   = level_out_reg;
    assign press_vec[gi]   = press_out_reg;
    assign release_vec[gi] = release_out_reg;
  end

  assign btn.btn_level   = level_vec;
  assign btn.btn_press   = press_vec;
  assign btn.btn_release = release_vec;
endmodule

// File: tb/tb_entrada_antirrebote.sv
// Bench for entrada_antirrebote: directed edge-timed checks plus random
// bouncing inputs compared every cycle against a run-length debounce model.
module tb_entrada_antirrebote;
  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  entrada_antirrebote_if #(.NUM_BTN(NB)) bus ();

  entrada_antirrebote #(
    .NUM_BTN(NB), .DEB_CYCLES(DEB), .ACTIVE_LOW(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int base       = 0;
  bit cmp_en     = 1'b0;

  logic [NB-1:0] exp_level   = '0;
  logic [NB-1:0] exp_press   = '0;
  logic [NB-1:0] exp_release = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: the conditioned level flips once DEB consecutive synchronized
  // samples disagree with it; outputs appear one edge after that decision.
  int pipe1[NB], pipe2[NB], mlevel[NB], run[NB], hold[NB], rep[NB];
  int pend_p[NB], pend_r[NB];
  initial begin
    int s;
    for (int c = 0; c < NB; c++) begin
      pipe1[c] = 0; pipe2[c] = 0; mlevel[c] = 0; run[c] = 0;
      hold[c] = 0; rep[c] = 0; pend_p[c] = 0; pend_r[c] = 0;
    end
    forever begin
      @(posedge clk);
      for (int c = 0; c < NB; c++) begin
        if (rst) begin
          pipe1[c] = 0; pipe2[c] = 0; mlevel[c] = 0; run[c] = 0;
          hold[c] = 0; rep[c] = 0; pend_p[c] = 0; pend_r[c] = 0;
          exp_level[c] = 1'b0; exp_press[c] = 1'b0; exp_release[c] = 1'b0;
        end else begin
          s = pipe2[c];
          pipe2[c] = pipe1[c];
          pipe1[c] = int'(bus.btn_in[c]);
          exp_level[c]   = (mlevel[c] != 0);
          exp_press[c]   = (pend_p[c] != 0);
          exp_release[c] = (pend_r[c] != 0);
          pend_p[c] = 0;
          pend_r[c] = 0;
          if (s != mlevel[c]) begin
            run[c]++;
            if (run[c] == DEB) begin
              mlevel[c] = s;
              run[c] = 0;
              if (s == 1) pend_p[c] = 1;
              else begin
                pend_r[c] = 1;
                hold[c] = 0;
                rep[c] = 0;
              end
            end
          end else begin
            if (mlevel[c] == 1 && run[c] == 0) begin
`ifdef AUTO_REPEAT_EN
              if (hold[c] == ((rep[c] != 0) ? RP : RD)) begin
                pend_p[c] = 1;
                hold[c] = 1;
                rep[c] = 1;
              end else begin
                hold[c]++;
              end
`endif
            end
            run[c] = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      compared++;
      if (bus.btn_level !== exp_level) begin
        mismatched++;
        $display("FAIL level t=%0t: got %b expected %b", $time, bus.btn_level, exp_level);
      end
      compared++;
      if (bus.btn_press !== exp_press) begin
        mismatched++;
        $display("FAIL press t=%0t: got %b expected %b", $time, bus.btn_press, exp_press);
      end
      compared++;
      if (bus.btn_release !== exp_release) begin
        mismatched++;
        $display("FAIL release t=%0t: got %b expected %b", $time, bus.btn_release, exp_release);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic start_scenario();
    bus.btn_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    base = cyc;
  endtask

  // Returns 1 time unit after scenario edge n.
  task automatic run_to(input int n);
    while (cyc < base + n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_pulse;
    int first_edge;
    int pe[$];
    int exp_edges[$];
    int remain[NB];

    bus.btn_in = '0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset_level", bus.btn_level, 0);
    chk("reset_press", bus.btn_press, 0);

    // Clean press, release, and a short low glitch while held.
    start_scenario();
    run_to(9);  bus.btn_in = 2'b01;
    run_to(15); chk("clean_press_e15", bus.btn_press, 2'b00);
    run_to(16); chk("clean_press_e16", bus.btn_press, 2'b01);
    chk("clean_level_e16", bus.btn_level, 2'b01);
    run_to(17); chk("clean_press_e17", bus.btn_press, 2'b00);
    run_to(39); bus.btn_in = 2'b00;
    run_to(45); chk("release_e45", bus.btn_release, 2'b00);
    chk("release_level_e45", bus.btn_level, 2'b01);
    run_to(46); chk("release_e46", bus.btn_release, 2'b01);
    chk("release_level_e46", bus.btn_level, 2'b00);
    run_to(49); bus.btn_in = 2'b01;
    run_to(69); bus.btn_in = 2'b00;
    run_to(71); bus.btn_in = 2'b01;
    n_pulse = 0;
    for (int k = 72; k <= 90; k++) begin
      run_to(k);
      if (bus.btn_release[0]) n_pulse++;
    end
    chk("glitch_no_release", n_pulse, 0);
    chk("glitch_level_e90", bus.btn_level, 2'b01);

    // Bounce: 1,1,0 then held high.
    start_scenario();
    run_to(9);  bus.btn_in = 2'b01;
    run_to(11); bus.btn_in = 2'b00;
    run_to(12); bus.btn_in = 2'b01;
    n_pulse = 0;
    first_edge = -1;
    for (int k = 10; k <= 30; k++) begin
      run_to(k);
      if (bus.btn_press[0]) begin
        n_pulse++;
        if (first_edge < 0) first_edge = k;
      end
    end
    chk("bounce_first_edge", first_edge, 19);
    chk("bounce_pulses", n_pulse, 1);

    // Simultaneous press on both channels.
    start_scenario();
    run_to(9);  bus.btn_in = 2'b11;
    run_to(16); chk("simul_press_e16", bus.btn_press, 2'b11);
    run_to(17); chk("simul_press_e17", bus.btn_press, 2'b00);

    // Reset mid-debounce.
    start_scenario();
    run_to(9);  bus.btn_in = 2'b01;
    run_to(12); rst = 1'b1;
    run_to(13); rst = 1'b0;
    chk("rstmid_outputs_e13", {bus.btn_level, bus.btn_press, bus.btn_release}, 0);
    run_to(19); chk("rstmid_press_e19", bus.btn_press, 2'b00);
    run_to(20); chk("rstmid_press_e20", bus.btn_press, 2'b01);

    // Long hold: repeat pulses only when the feature is built in.
    start_scenario();
    run_to(9); bus.btn_in = 2'b01;
    pe.delete();
    for (int k = 10; k <= 76; k++) begin
      run_to(k);
      if (bus.btn_press[0]) pe.push_back(k);
    end
`ifdef AUTO_REPEAT_EN
    exp_edges = '{16, 37, 45, 53, 61, 69};
`else
    exp_edges = '{16};
`endif
    chk("hold_pulse_count", pe.size(), exp_edges.size());
    for (int i = 0; i < exp_edges.size() && i < pe.size(); i++)
      chk($sformatf("hold_pulse_%0d_edge", i), pe[i], exp_edges[i]);

    // Random bouncing levels with occasional resets, checked by the model.
    start_scenario();
    for (int c = 0; c < NB; c++) remain[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < NB; c++) begin
        if (remain[c] == 0) begin
          bus.btn_in[c] = 1'($urandom_range(0, 1));
          remain[c] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 60))
                                                  : int'($urandom_range(1, 8));
        end else begin
          remain[c]--;
        end
      end
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
